alu_arbiter: RTL

Shares the single 5-bit combinational ALU datapath (A, B, OP in; R, ZF out) between two independent requesters.
- Accepts one request at a time using round-robin arbitration.
- Registers the operands onto the ALU inputs and captures the ALU result one cycle later.
- Returns the result, zero flag and requester ID with a one-cycle valid pulse.
- Sits between requester logic and the ALU instance, replacing direct controller-to-ALU wiring in the top level.

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between two requesters.
// Each accepted operation takes IDLE -> EXEC -> RESP; every output comes from a flop.
module alu_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zf,
    output logic [WIDTH-1:0] res,
    output logic             res_zf,
    output logic             res_id,
    output logic             res_valid,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg, state_next;
    logic             last_reg, last_next;
    logic             owner_reg, owner_next;
    logic             gnt0_reg, gnt0_next;
    logic             gnt1_reg, gnt1_next;
    logic [WIDTH-1:0] alu_a_reg, alu_a_next;
    logic [WIDTH-1:0] alu_b_reg, alu_b_next;
    logic             alu_op_reg, alu_op_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             res_zf_reg, res_zf_next;
    logic             res_id_reg, res_id_next;
    logic             res_valid_reg, res_valid_next;
    logic             busy_reg, busy_next;
    logic             win0, win1;

    // On a tie the requester that was not served last wins.
    assign win0 = req0 && (!req1 || last_reg);
    assign win1 = req1 && (!req0 || !last_reg);

    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        owner_next     = owner_reg;
        gnt0_next      = 1'b0;
        gnt1_next      = 1'b0;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_op_next    = alu_op_reg;
        res_next       = res_reg;
        res_zf_next    = res_zf_reg;
        res_id_next    = res_id_reg;
        res_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win0) begin
                    alu_a_next  = a0;
                    alu_b_next  = b0;
                    alu_op_next = op0;
                    gnt0_next   = 1'b1;
                    last_next   = 1'b0;
                    owner_next  = 1'b0;
                    state_next  = EXEC;
                end else if (win1) begin
                    alu_a_next  = a1;
                    alu_b_next  = b1;
                    alu_op_next = op1;
                    gnt1_next   = 1'b1;
                    last_next   = 1'b1;
                    owner_next  = 1'b1;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                res_next       = alu_r;
                res_zf_next    = alu_zf;
                res_id_next    = owner_reg;
                res_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // Asynchronous assertion aborts any operation in flight without a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            owner_reg     <= 1'b0;
            gnt0_reg      <= 1'b0;
            gnt1_reg      <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= 1'b0;
            res_reg       <= '0;
            res_zf_reg    <= 1'b0;
            res_id_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            owner_reg     <= owner_next;
            gnt0_reg      <= gnt0_next;
            gnt1_reg      <= gnt1_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_op_reg    <= alu_op_next;
            res_reg       <= res_next;
            res_zf_reg    <= res_zf_next;
            res_id_reg    <= res_id_next;
            res_valid_reg <= res_valid_next;
            busy_reg      <= busy_next;
        end
    end

    assign gnt0      = gnt0_reg;
    assign gnt1      = gnt1_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign res       = res_reg;
    assign res_zf    = res_zf_reg;
    assign res_id    = res_id_reg;
    assign res_valid = res_valid_reg;
    assign busy      = busy_reg;

endmodule
